// File: rtl/scene_pixel_fetch.sv
// Per-pixel fetch stage ahead of the palette lookup: background/sprite ROM addressing,
// once-per-frame position/scene latch, scene-change black-out and 3-clock compositing pipeline.
module scene_pixel_fetch #(
  parameter int SPR_W        = 16,
  parameter int SPR_H        = 16,
  parameter int BG_W         = 320,
  parameter int BLACK_FRAMES = 8,
  localparam int SA_W        = $clog2(SPR_W * SPR_H)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_start,
  input  logic [9:0]      DrawX,
  input  logic [9:0]      DrawY,
  input  logic            vde,
  input  logic [1:0]      scene_req,
  input  logic [9:0]      player_x,
  input  logic [9:0]      player_y,
  input  logic            player_show,
  output logic [16:0]     bg_addr,
  input  logic [7:0]      bg_data,
  output logic [SA_W-1:0] spr_addr,
  input  logic [3:0]      spr_data,
  output logic [1:0]      select,
  output logic [3:0]      palette_color,
  output logic [7:0]      map_palette_color,
  output logic [4:0]      start_palette_color,
  output logic [5:0]      gym_palette_color,
  output logic            vde_out
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int CW = (BLACK_FRAMES > 1) ? $clog2(BLACK_FRAMES + 1) : 1;

  typedef enum logic [1:0] {SC_START = 2'd0, SC_MAP = 2'd1, SC_GYM = 2'd2} scene_t;
  typedef enum logic {ST_NORMAL = 1'b0, ST_BLACK = 1'b1} state_t;

  logic [9:0]  px_lat, py_lat;
  logic        show_lat;
  scene_t      scene_cur, scene_new;
  state_t      state;
  logic [CW-1:0] black_cnt;

  assign scene_new = (scene_req == 2'd3) ? SC_START : scene_t'(scene_req);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      px_lat    <= '0;
      py_lat    <= '0;
      show_lat  <= 1'b0;
      scene_cur <= SC_START;
      state     <= ST_NORMAL;
      black_cnt <= '0;
    end else if (frame_start) begin
      px_lat    <= player_x;
      py_lat    <= player_y;
      show_lat  <= player_show;
      scene_cur <= scene_new;
      if (BLACK_FRAMES > 0 && scene_new != scene_cur) begin
        state     <= ST_BLACK;
        black_cnt <= CW'(BLACK_FRAMES);
      end else if (state == ST_BLACK) begin
        if (black_cnt == CW'(1)) begin
          state     <= ST_NORMAL;
          black_cnt <= '0;
        end else begin
          black_cnt <= black_cnt - CW'(1);
        end
      end
    end
  end

  // 11-bit compares so a sprite near column 639 clips instead of wrapping to column 0
  logic [10:0] x11, y11, px11, py11;
  logic        hit_c;
  logic [XW-1:0] dx_off;
  logic [YW-1:0] dy_off;
  logic [SA_W-1:0] spr_addr_c;
  logic [16:0] bg_addr_c;

  assign x11  = {1'b0, DrawX};
  assign y11  = {1'b0, DrawY};
  assign px11 = {1'b0, px_lat};
  assign py11 = {1'b0, py_lat};
  assign hit_c = show_lat && (x11 >= px11) && (x11 < px11 + 11'(SPR_W))
                          && (y11 >= py11) && (y11 < py11 + 11'(SPR_H));
  assign dx_off = XW'(DrawX - px_lat);
  assign dy_off = YW'(DrawY - py_lat);
  assign spr_addr_c = hit_c ? {dy_off, dx_off} : '0;
  assign bg_addr_c  = vde ? 17'(17'(DrawY[9:1]) * 17'(BG_W)) + 17'(DrawX[9:1]) : '0;

  logic   vde_s0, hit_s0, black_s0;
  logic   vde_s1, hit_s1, black_s1;
  scene_t scene_s0, scene_s1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bg_addr  <= '0;
      spr_addr <= '0;
      vde_s0   <= 1'b0;
      hit_s0   <= 1'b0;
      black_s0 <= 1'b0;
      scene_s0 <= SC_START;
      vde_s1   <= 1'b0;
      hit_s1   <= 1'b0;
      black_s1 <= 1'b0;
      scene_s1 <= SC_START;
    end else begin
      bg_addr  <= bg_addr_c;
      spr_addr <= spr_addr_c;
      vde_s0   <= vde;
      hit_s0   <= hit_c;
      black_s0 <= (state == ST_BLACK);
      scene_s0 <= scene_cur;
      vde_s1   <= vde_s0;
      hit_s1   <= hit_s0;
      black_s1 <= black_s0;
      scene_s1 <= scene_s0;
    end
  end

  logic [1:0] sel_c;
  logic [3:0] pal_c;
  logic [7:0] map_c;
  logic [4:0] start_c;
  logic [5:0] gym_c;
  logic       bg_unused;

  assign bg_unused = bg_data[7];

  always_comb begin
    sel_c   = 2'd2;
    pal_c   = '0;
    map_c   = '0;
    start_c = '0;
    gym_c   = '0;
    if (!vde_s1 || black_s1) begin
      gym_c = 6'd28;
    end else if (hit_s1 && spr_data != '0 && scene_s1 != SC_START) begin
      sel_c = 2'd0;
      pal_c = spr_data;
    end else begin
      case (scene_s1)
        SC_MAP: begin
          sel_c = 2'd1;
          map_c = {1'b0, bg_data[6:0]};
        end
        SC_GYM: begin
          sel_c = 2'd2;
          gym_c = bg_data[5:0];
        end
        default: begin
          sel_c   = 2'd3;
          start_c = bg_data[4:0];
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      select              <= 2'd2;
      palette_color       <= '0;
      map_palette_color   <= '0;
      start_palette_color <= '0;
      gym_palette_color   <= 6'd28;
      vde_out             <= 1'b0;
    end else begin
      select              <= sel_c;
      palette_color       <= pal_c;
      map_palette_color   <= map_c;
      start_palette_color <= start_c;
      gym_palette_color   <= gym_c;
      vde_out             <= vde_s1;
    end
  end

endmodule

// File: tb/tb_scene_pixel_fetch.sv
// Randomized + directed bench for scene_pixel_fetch against a frame-level reference model
// with behavioural background/sprite ROMs.
module tb_scene_pixel_fetch;
  localparam int BF = 2;
  localparam logic [25:0] RST_OUT = {1'b0, 2'd2, 4'd0, 8'd0, 5'd0, 6'd28};

  logic       Clk = 1'b0, Reset = 1'b1, frame_start = 1'b0, vde = 1'b0, player_show = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, player_x = '0, player_y = '0;
  logic [1:0] scene_req = '0;
  logic [16:0] bg_addr;
  logic [7:0]  bg_data = '0;
  logic [7:0]  spr_addr;
  logic [3:0]  spr_data = '0;
  logic [1:0]  select;
  logic [3:0]  palette_color;
  logic [7:0]  map_palette_color;
  logic [4:0]  start_palette_color;
  logic [5:0]  gym_palette_color;
  logic        vde_out;

  scene_pixel_fetch #(.SPR_W(16), .SPR_H(16), .BG_W(320), .BLACK_FRAMES(BF)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
    .vde(vde), .scene_req(scene_req), .player_x(player_x), .player_y(player_y),
    .player_show(player_show), .bg_addr(bg_addr), .bg_data(bg_data), .spr_addr(spr_addr),
    .spr_data(spr_data), .select(select), .palette_color(palette_color),
    .map_palette_color(map_palette_color), .start_palette_color(start_palette_color),
    .gym_palette_color(gym_palette_color), .vde_out(vde_out));

  always #5 Clk = ~Clk;

  function automatic logic [7:0] bg_fn(input logic [16:0] a);
    return a[7:0] ^ a[16:9] ^ 8'h5A;
  endfunction

  logic [3:0] spr_rom [256];
  always @(posedge Clk) begin
    bg_data  <= bg_fn(bg_addr);
    spr_data <= spr_rom[spr_addr];
  end

  int vectors = 0, errors = 0;
  int m_px, m_py, m_scene, m_black;
  bit m_show;
  logic [25:0] exp_q[$];
  logic [16:0] exp_bg_prev;
  logic [7:0]  exp_spr_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [25:0] pack(input bit v, input int sel, input int pal,
                                       input int mp, input int st, input int gy);
    return {v, 2'(sel), 4'(pal), 8'(mp), 5'(st), 6'(gy)};
  endfunction

  function automatic logic [25:0] outs();
    return {vde_out, select, palette_color, map_palette_color, start_palette_color,
            gym_palette_color};
  endfunction

  task automatic model_reset();
    m_px = 0; m_py = 0; m_scene = 0; m_black = 0; m_show = 0;
    exp_q = {};
    repeat (3) exp_q.push_back(RST_OUT);
    exp_bg_prev = '0;
    exp_spr_prev = '0;
  endtask

  // One pixel clock: check what the pipeline owes this cycle, then apply new inputs.
  task automatic step(input bit fs, input int x, input int y, input bit v, input int req,
                      input int pxi, input int pyi, input bit shw);
    int addr, sidx, ns;
    bit hit;
    logic [7:0] bg;
    logic [3:0] sp;
    logic [25:0] e;
    @(negedge Clk);
    check_eq("bg_addr", bg_addr, exp_bg_prev);
    check_eq("spr_addr", spr_addr, exp_spr_prev);
    check_eq("pixel", outs(), exp_q.pop_front());
    frame_start = fs; DrawX = 10'(x); DrawY = 10'(y); vde = v; scene_req = 2'(req);
    player_x = 10'(pxi); player_y = 10'(pyi); player_show = shw;

    addr = v ? ((y / 2) * 320 + x / 2) % 131072 : 0;
    hit  = m_show && x >= m_px && x < m_px + 16 && y >= m_py && y < m_py + 16;
    sidx = hit ? (y - m_py) * 16 + (x - m_px) : 0;
    bg   = bg_fn(17'(addr));
    sp   = spr_rom[sidx];
    if (!v || m_black > 0)                   e = pack(v, 2, 0, 0, 0, 28);
    else if (hit && sp != 0 && m_scene != 0) e = pack(1, 0, sp, 0, 0, 0);
    else if (m_scene == 1)                   e = pack(1, 1, 0, bg[6:0], 0, 0);
    else if (m_scene == 2)                   e = pack(1, 2, 0, 0, 0, bg[5:0]);
    else                                     e = pack(1, 3, 0, 0, bg[4:0], 0);
    exp_q.push_back(e);
    exp_bg_prev  = 17'(addr);
    exp_spr_prev = 8'(sidx);

    if (fs) begin
      ns = (req == 3) ? 0 : req;
      if (ns != m_scene) m_black = BF;
      else if (m_black > 0) m_black--;
      m_scene = ns; m_px = pxi; m_py = pyi; m_show = shw;
    end
  endtask

  task automatic frame(input int req, input int pxi, input int pyi, input bit shw);
    step(1, 0, 0, 0, req, pxi, pyi, shw);
  endtask

  task automatic pix(input int x, input int y);
    step(0, x, y, 1, int'(scene_req), int'(player_x), int'(player_y), player_show);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, int'(scene_req), int'(player_x), int'(player_y), player_show);
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check_eq("rst_async_pixel", outs(), RST_OUT);
    check_eq("rst_async_bg_addr", bg_addr, 0);
    check_eq("rst_async_spr_addr", spr_addr, 0);
    frame_start = 1'b0; vde = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int req, px, py, x, y, r;
    for (int i = 0; i < 256; i++) spr_rom[i] = 4'($urandom);
    spr_rom[35] = 4'd5;

    repeat (2) @(negedge Clk);
    check_eq("reset_pixel", outs(), RST_OUT);
    check_eq("reset_bg_addr", bg_addr, 0);
    Reset = 1'b0;
    model_reset();

    // START scene, address arithmetic
    frame(0, 0, 0, 0);
    pix(2, 2); pix(0, 0); pix(639, 479); pix(1, 3);
    idle(3);

    // START -> MAP: two black frames, then sprite over map
    frame(1, 100, 50, 1); pix(103, 52); pix(10, 10); idle(2);
    frame(1, 100, 50, 1); pix(103, 52); idle(2);
    frame(1, 100, 50, 1); pix(103, 52); pix(100, 50); pix(115, 65); pix(116, 65); idle(4);
    spr_rom[35] = 4'd0;
    pix(103, 52); idle(4);
    spr_rom[35] = 4'd5;

    // right-edge clipping and mid-frame position change
    frame(1, 630, 50, 1); pix(639, 55); pix(5, 55); pix(629, 55);
    step(0, 639, 55, 1, 1, 200, 50, 1); pix(639, 55); pix(205, 55);
    frame(1, 200, 50, 1); pix(205, 55); pix(639, 55);

    // MAP -> GYM, then a change during black-out reloads the counter
    frame(2, 200, 50, 1); pix(205, 55); pix(40, 40);
    frame(2, 200, 50, 1); pix(40, 40);
    frame(2, 200, 50, 1); pix(40, 40); pix(205, 55);
    frame(1, 200, 50, 1); pix(40, 40);
    frame(1, 200, 50, 1); pix(40, 40);
    frame(0, 200, 50, 1); pix(40, 40);
    frame(0, 200, 50, 1); pix(40, 40);
    frame(0, 200, 50, 1); pix(40, 40);
    frame(0, 200, 50, 1); pix(40, 40); pix(205, 55);

    // blanking with an off-screen row, scene code 3 aliases START
    step(0, 10, 500, 0, 0, 200, 50, 1);
    frame(3, 200, 50, 1); pix(205, 55); idle(3);

    pulse_reset();
    pix(205, 55); pix(2, 2); idle(3);

    for (int f = 0; f < 14; f++) begin
      req = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'(scene_req);
      px  = $urandom_range(0, 630);
      py  = $urandom_range(0, 470);
      frame(req, px, py, $urandom_range(0, 5) != 0);
      for (int p = 0; p < 50; p++) begin
        r = $urandom_range(0, 1);
        x = r ? (px + $urandom_range(0, 19) + 1022) % 1024 : $urandom_range(0, 639);
        y = r ? (py + $urandom_range(0, 19) + 1022) % 1024 : $urandom_range(0, 479);
        if ($urandom_range(0, 15) == 0)
          step(0, x, y, 1, $urandom_range(0, 3), $urandom_range(0, 630),
               $urandom_range(0, 470), $urandom_range(0, 1));
        else
          step(0, x, y, $urandom_range(0, 9) != 0, int'(scene_req), int'(player_x),
               int'(player_y), player_show);
      end
      if (f == 7) pulse_reset();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/scene_pixel_fetch.md
Name: scene_pixel_fetch

Overview:
- Upstream stage of the palette lookup. Per pixel it turns VGA DrawX/DrawY into ROM addresses, then composites the player sprite over the scene background.
- Outputs the palette-select code and the palette index fields that the palette lookup converts to 24-bit RGB.
- Latches the scene and sprite position once per frame, and inserts a black-out period on scene changes.

Parameters:
SPR_W, 16, sprite width in pixels (power of two)
SPR_H, 16, sprite height in pixels (power of two)
BG_W, 320, background ROM row width (screen is 2x upscaled from 320x240)
BLACK_FRAMES, 8, number of full black frames after a scene change; 0 disables black-out

Ports:
Clk  in  1  pixel clock
Reset  in  1  asynchronous active-high reset
frame_start  in  1  one-cycle pulse at the start of vertical blank
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
vde  in  1  display-enable, high in the visible area
scene_req  in  2  requested scene: 0 START, 1 MAP, 2 GYM (3 treated as START)
player_x  in  10  sprite top-left X
player_y  in  10  sprite top-left Y
player_show  in  1  sprite visible
bg_addr  out  17  background index ROM address
bg_data  in  8  background ROM data, valid 1 clock after bg_addr
spr_addr  out  clog2(SPR_W*SPR_H)  sprite ROM address
spr_data  in  4  sprite ROM data, valid 1 clock after spr_addr
select  out  2  palette select: 0 sprite, 1 map, 2 gym, 3 start
palette_color  out  4  sprite palette index
map_palette_color  out  8  map palette index
start_palette_color  out  5  start palette index
gym_palette_color  out  6  gym palette index
vde_out  out  1  vde delayed to align with the outputs

Behaviour:
- Reset, asynchronous:
  - select=2, gym_palette_color=28 (black), all other outputs 0.
  - Latched position=0, show=0, scene_cur=START, state NORMAL, black counter 0.
  - Pipeline valid bits cleared.
- Frame latch. On frame_start:
  - latch player_x/player_y/player_show into the internal position registers;
  - scene_req (3 mapped to 0) loads scene_cur.
  - The latched values are used for the whole following frame; mid-frame input changes have no effect.
- Black-out FSM, states NORMAL and BLACK:
  - On frame_start, if the new scene differs from scene_cur and BLACK_FRAMES>0: go to BLACK, counter=BLACK_FRAMES.
  - In BLACK, each later frame_start decrements the counter; at the frame_start where the counter is 1, return to NORMAL.
  - A scene change while in BLACK reloads the counter.
  - If BLACK_FRAMES=0, stay in NORMAL.
- Pipeline, fixed latency 3 clocks from DrawX/DrawY/vde to outputs/vde_out:
  - S0, registered at the end of cycle n:
    - bg_addr = (DrawY>>1)*BG_W + (DrawX>>1), computed in 17 bits; forced to 0 when vde=0.
    - hit = show_lat && DrawX>=px && DrawX<px+SPR_W && DrawY>=py && DrawY<py+SPR_H, compared in 11 bits so a sprite at the screen edge is clipped with no wrap.
    - spr_addr = (DrawY-py)*SPR_W + (DrawX-px) when hit, else 0.
    - vde, hit and the scene/state snapshot are delayed alongside.
  - S1 (cycle n+1): the ROMs sample their addresses.
  - S2 (cycle n+2): ROM data is valid; outputs are registered, valid in cycle n+3.
- Compositing in S2, first match wins:
  1. vde=0 or state BLACK: select=2, gym=28.
  2. hit && spr_data!=0 && scene!=START: select=0, palette_color=spr_data. spr_data 0 is transparent.
  3. MAP: select=1, map_palette_color={1'b0, bg_data[6:0]}.
  4. GYM: select=2, gym_palette_color=bg_data[5:0].
  5. START: select=3, start_palette_color=bg_data[4:0].
- Index fields not used by the current select are driven to 0.
- Scene and state for compositing come from the snapshot taken in S0, so a frame_start edge never splits a pixel's decision.
- Reset asserted mid-line: outputs take reset values immediately; the first valid output is 3 clocks after deassertion.

Test Plan:
- Reset, then vde=1 with scene START latched, DrawX=2, DrawY=2, bg_data=0x13 returned one clock after bg_addr -> bg_addr=321 one clock later; three clocks later select=3, start_palette_color=19, vde_out=1.
- MAP scene, player at (100,50) shown, DrawX=103, DrawY=52, spr_data=5 -> spr_addr=35, select=0, palette_color=5. Same pixel with spr_data=0 -> select=1, map index=bg_data[6:0].
- player_x=630, DrawX=639 hits and DrawX=5 does not hit (no wrap). player_x changed mid-frame -> hit region unchanged until the next frame_start.
- scene_req changes MAP->GYM, BLACK_FRAMES=2 -> two full frames of select=2, gym=28, then GYM pixels from the third frame. A further change during BLACK reloads the counter to 2.
- vde=0 with DrawY=500 -> bg_addr=0, select=2, gym=28, vde_out=0 three clocks later.
- Reset pulsed mid-frame -> outputs return to reset values in the same cycle with no clock edge needed; scene returns to START.
